// File: rtl/dstream_frame_capture_if.sv
// Pixel dstream handshake bundle: data/valid flow downstream, ready flows back.
interface dstream #(
    parameter int W = 30
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport sink   (input data, input valid, output ready);
    modport source (output data, output valid, input ready);
endinterface

// File: rtl/dstream_frame_capture.sv
// Frame capture sink: writes each accepted dstream pixel into a frame-buffer port,
// starting at a fixed offset so filter fill delay lands pixels centred.
module dstream_frame_capture #(
    parameter int W            = 30,
    parameter int OUT_BW       = 4,
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_OFFSET  = 642,
    parameter int AW           = $clog2(WIDTH*HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    dstream.sink                x,
    input  logic                start,
    input  logic                continuous,
    input  logic                mem_stall,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [3*OUT_BW-1:0] wr_data,
    output logic                busy,
    output logic                frame_done,
    output logic [AW:0]         pix_count
);
    localparam int C = W / 3;
    localparam logic [AW-1:0] START_ADDR = AW'(ADDR_OFFSET);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(WIDTH*HEIGHT - 1);
    localparam logic [AW:0]   LAST_PIX   = (AW+1)'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic          hs, last, load;

    // ready never looks at valid, so the upstream chain sees no comb loop
    assign x.ready    = (state == CAPTURE) && !mem_stall;
    assign busy       = (state == CAPTURE);
    assign frame_done = (state == DONE);
    assign hs         = x.valid && x.ready;
    assign last       = hs && (pix_count == LAST_PIX);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    load      = 1'b1;
                end
            end
            CAPTURE: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                load      = continuous | start;
                state_nxt = (continuous | start) ? CAPTURE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            pix_count <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= hs;
            if (load) begin
                ptr       <= START_ADDR;
                pix_count <= '0;
            end else if (hs) begin
                ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
                pix_count <= pix_count + (AW+1)'(1);
            end
            // address/data hold when no pixel is accepted
            if (hs) begin
                wr_addr <= ptr;
                wr_data <= {x.data[W-1 -: OUT_BW], x.data[2*C-1 -: OUT_BW], x.data[C-1 -: OUT_BW]};
            end
        end
    end
endmodule
